// File: rtl/mean_reflector_pkg.sv
// mean_reflector shared types and constants
// Default geometry, derived widths, saturation bounds and FSM states
package mean_reflector_pkg;

    localparam int NUM_QUBIT_DEF  = 4;
    localparam int DATA_WIDTH_DEF = 32;

    localparam int N      = 1 << NUM_QUBIT_DEF;
    localparam int SUM_W  = DATA_WIDTH_DEF + NUM_QUBIT_DEF;
    localparam int MEAN_W = DATA_WIDTH_DEF + 1;

    localparam longint SAT_MAX = (64'sd1 <<< (DATA_WIDTH_DEF - 1)) - 1;
    localparam longint SAT_MIN = -(64'sd1 <<< (DATA_WIDTH_DEF - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEAN = 2'd1,
        EMIT = 2'd2
    } state_e;

endpackage

// File: rtl/mean_reflector_if.sv
// mean_reflector handshake bundle
// master drives vectors and out_ready, slave is the reflector
interface mean_reflector_if #(
    parameter int NUM_QUBIT  = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int VN = 1 << NUM_QUBIT;

    logic                            in_valid;
    logic                            in_ready;
    logic [VN*DATA_WIDTH-1:0]        in_vec;
    logic [DATA_WIDTH+NUM_QUBIT-1:0] in_sum;
    logic                            out_valid;
    logic                            out_ready;
    logic [DATA_WIDTH-1:0]           out_data;
    logic [NUM_QUBIT-1:0]            out_index;
    logic                            out_last;
    logic                            busy;

    modport master (
        output in_valid, in_vec, in_sum, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last, busy
    );

    modport slave (
        input  in_valid, in_vec, in_sum, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last, busy
    );

endinterface

// File: rtl/mean_reflector_reflect_sat.sv
// reflect_sat: saturated 2*mean - a
// Widened by three bits so the difference never wraps before clamping
module reflect_sat #(
    parameter int DATA_WIDTH = 32,
    parameter int MEAN_W     = DATA_WIDTH + 1
) (
    input  logic signed [MEAN_W-1:0]     mean,
    input  logic signed [DATA_WIDTH-1:0] amp,
    output logic signed [DATA_WIDTH-1:0] res
);
    localparam int CW = DATA_WIDTH + 3;
    localparam logic signed [CW-1:0] HI = {4'b0000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [CW-1:0] LO = {4'b1111, {(DATA_WIDTH-1){1'b0}}};

    logic signed [CW-1:0] m_x;
    logic signed [CW-1:0] a_x;
    logic signed [CW-1:0] diff;

    // reflect about the mean, then clamp to the amplitude range
    always_comb begin
        m_x  = {{(CW-MEAN_W){mean[MEAN_W-1]}}, mean};
        a_x  = {{3{amp[DATA_WIDTH-1]}}, amp};
        diff = (m_x <<< 1) - a_x;
        if (diff > HI) begin
            res = HI[DATA_WIDTH-1:0];
        end else if (diff < LO) begin
            res = LO[DATA_WIDTH-1:0];
        end else begin
            res = diff[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mean_reflector.sv
// mean_reflector: inversion about the mean, one beat per handshake
// Captures a vector and its sum, derives the mean, streams reflections
module mean_reflector
    import mean_reflector_pkg::*;
#(
    parameter int NUM_QUBIT  = 4,
    parameter int DATA_WIDTH = 32
) (
    input logic              clk,
    input logic              rst_n,
    mean_reflector_if.slave  bus
);
    localparam int VN    = 1 << NUM_QUBIT;
    localparam int SW    = DATA_WIDTH + NUM_QUBIT;
    localparam int MW    = DATA_WIDTH + 1;
    localparam int VW    = VN * DATA_WIDTH;
    localparam logic [NUM_QUBIT-1:0] LAST = NUM_QUBIT'(VN - 1);

    state_e                state_q, state_d;
    logic [NUM_QUBIT-1:0]  idx_q, idx_d;
    logic signed [MW-1:0]  mean_q, mean_d;
    logic [VW-1:0]         vec_q, vec_d;
    logic signed [SW-1:0]  sum_q, sum_d;

    logic signed [DATA_WIDTH-1:0] amp;
    logic signed [DATA_WIDTH-1:0] refl;

    // FSM, capture and index advance
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mean_d  = mean_q;
        vec_d   = vec_q;
        sum_d   = sum_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    vec_d   = bus.in_vec;
                    sum_d   = bus.in_sum;
                    state_d = MEAN;
                end
            end
            MEAN: begin
                mean_d  = MW'(sum_q >>> NUM_QUBIT);
                idx_d   = '0;
                state_d = EMIT;
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (idx_q == LAST) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mean_q  <= '0;
            vec_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mean_q  <= mean_d;
            vec_q   <= vec_d;
            sum_q   <= sum_d;
        end
    end

    reflect_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEAN_W     (MW)
    ) u_reflect_sat (
        .mean (mean_q),
        .amp  (amp),
        .res  (refl)
    );

    // output mux, driven purely from registered state
    always_comb begin
        amp           = vec_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
        bus.in_ready  = (state_q == IDLE);
        bus.busy      = (state_q != IDLE);
        bus.out_valid = (state_q == EMIT);
        bus.out_index = idx_q;
        bus.out_last  = (state_q == EMIT) && (idx_q == LAST);
        bus.out_data  = (state_q == EMIT) ? refl : '0;
    end

endmodule

// File: tb/tb_mean_reflector.sv
// tb_mean_reflector: scoreboard bench, NUM_QUBIT=2 DATA_WIDTH=8
// Expected beats come from a floor-mean reflection model
module tb_mean_reflector;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mean_reflector_if #(.NUM_QUBIT(2), .DATA_WIDTH(8)) bus ();

    mean_reflector #(.NUM_QUBIT(2), .DATA_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] idx;
        logic       last;
    } beat_t;

    beat_t sb[$];
    int n_checks = 0;
    int n_err = 0;
    int hs_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int a0, input int a1, input int a2,
                            input int a3, input int sum);
        int a[4];
        int m;
        int r;
        a = '{a0, a1, a2, a3};
        m = sum >>> 2;
        for (int i = 0; i < 4; i++) begin
            r = 2 * m - a[i];
            if (r > 127) r = 127;
            if (r < -128) r = -128;
            sb.push_back('{8'(r), 2'(i), (i == 3)});
        end
    endtask

    task automatic drive_vec(input int a0, input int a1, input int a2,
                             input int a3, input int sum);
        bus.in_vec = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
        bus.in_sum = 10'(sum);
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (bus.in_ready !== 1'b1 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("ready_wait", bus.in_ready, 1);
    endtask

    task automatic send(input int a0, input int a1, input int a2,
                        input int a3, input int sum);
        wait_ready();
        drive_vec(a0, a1, a2, a3, sum);
        bus.in_valid = 1'b1;
        push_exp(a0, a1, a2, a3, sum);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int start, output int cyc);
        cyc = start;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.in_ready === 1'b1) break;
        end
        chk("idle_reached", bus.in_ready, 1);
    endtask

    // monitor: pop on handshake, check holds while stalled
    initial begin
        beat_t e;
        beat_t hold;
        bit stall;
        stall = 1'b0;
        hold = '{8'd0, 2'd0, 1'b0};
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stall) begin
                    chk("hold_valid", bus.out_valid, 1);
                    chk("hold_data", bus.out_data, hold.data);
                    chk("hold_index", bus.out_index, hold.idx);
                    chk("hold_last", bus.out_last, hold.last);
                end
                chk("busy_cpl", bus.busy, !bus.in_ready);
                if (bus.out_valid && bus.out_ready) begin
                    hs_cnt++;
                    chk("sb_nonempty", 32'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("beat_data", bus.out_data, e.data);
                        chk("beat_index", bus.out_index, e.idx);
                        chk("beat_last", bus.out_last, e.last);
                    end
                end
                stall = bus.out_valid && !bus.out_ready;
                hold = '{bus.out_data, bus.out_index, bus.out_last};
            end else begin
                stall = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int hs0;
        bit seen;
        bit pat[7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive_vec(0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_index", bus.out_index, 0);
        chk("rst_out_last", bus.out_last, 0);
        rst_n = 1'b1;

        // basic vector with cycle-accurate timing
        send(10, 20, 30, 40, 100);
        @(negedge clk);
        chk("c1_out_valid", bus.out_valid, 0);
        chk("c1_busy", bus.busy, 1);
        @(negedge clk);
        chk("c2_out_valid", bus.out_valid, 1);
        chk("c2_out_index", bus.out_index, 0);
        wait_idle(2, cyc);
        chk("basic_ready_cyc", cyc, 6);

        // negative floor mean
        send(-1, 0, 0, 0, -1);
        wait_idle(0, cyc);
        chk("neg_ready_cyc", cyc, 6);

        // saturation
        send(127, 127, 127, -128, 253);
        wait_idle(0, cyc);
        chk("sat_ready_cyc", cyc, 6);

        // backpressure
        hs0 = hs_cnt;
        send(10, 20, 30, 40, 100);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            bus.out_ready = pat[i];
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        chk("bp_handshakes", hs_cnt - hs0, 4);
        wait_idle(0, cyc);

        // reset mid-stream
        send(10, 20, 30, 40, 100);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.out_valid && bus.out_ready && (bus.out_index == 2'd1);
        end
        chk("beat1_seen", 32'(seen), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_out_last", bus.out_last, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst_ready", bus.in_ready, 1);
        chk("post_rst_busy", bus.busy, 0);
        send(0, 0, 0, 4, 4);
        wait_idle(0, cyc);

        // in_valid held high during EMIT with a different vector
        send(10, 20, 30, 40, 100);
        drive_vec(1, 2, 3, 4, 10);
        bus.in_valid = 1'b1;
        push_exp(1, 2, 3, 4, 10);
        wait_idle(0, cyc);
        chk("held_accept_cyc", cyc, 6);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("held_accepted", bus.busy, 1);
        wait_idle(0, cyc);

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mean_reflector.md
# mean_reflector

Sequential inversion-about-mean stage of the Grover diffusion datapath. Accepts a full state vector of 2^NUM_QUBIT signed fixed-point amplitudes together with their precomputed sum from the upstream adder tree. Derives the mean and streams out the reflected amplitudes 2·mean − a_i, one per beat, over a valid/ready handshake. Sits between the amplitude-sum stage and the state-vector write-back buffer.

## Interface
- NUM_QUBIT, 4, qubit count; vector length N = 2^NUM_QUBIT
- DATA_WIDTH, 32, signed two's-complement amplitude width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  vector and sum presented
- in_ready  out  1  block can accept a vector (high only in IDLE)
- in_vec  in  N·DATA_WIDTH  amplitudes; a_i = in_vec[DATA_WIDTH·(i+1)−1 -: DATA_WIDTH]
- in_sum  in  DATA_WIDTH+NUM_QUBIT  signed sum of all a_i
- out_valid  out  1  reflected amplitude available
- out_ready  in  1  downstream accepts beat
- out_data  out  DATA_WIDTH  reflected amplitude, saturated
- out_index  out  NUM_QUBIT  index i of out_data
- out_last  out  1  high with the beat where i = N−1
- busy  out  1  high in any state other than IDLE

## Operation
- One clock and one reset domain. Reset is asynchronous, active-low.
- FSM states: IDLE, MEAN, EMIT.
- IDLE: in_ready=1. When in_valid&in_ready, register in_vec and in_sum, then go to MEAN.
- MEAN: mean_r = in_sum_r >>> NUM_QUBIT.
  - Arithmetic shift, so rounding is floor toward −∞.
  - Keep mean_r in DATA_WIDTH+1 bits. This is lossless.
  - Clear idx to 0. Go to EMIT.
- EMIT: out_valid=1 and out_data = sat(2·mean_r − a_idx).
  - Compute in DATA_WIDTH+3 bits signed.
  - Saturate to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- EMIT, on out_valid&out_ready:
  - If idx = N−1: go to IDLE.
  - Otherwise: idx+1.
- Without out_ready, all of out_data, out_index and out_last stay stable. idx does not wrap.
- in_valid is ignored outside IDLE. The stored vector is not overwritten mid-stream.
- Reset values:
  - State IDLE, idx 0, mean_r 0, stored vector and sum 0.
  - out_valid 0, out_data 0, out_index 0, out_last 0.
  - busy 0, in_ready 1.
- Reset asserted in MEAN or EMIT aborts the stream immediately. No further beats are emitted. After release, the block is in IDLE.

## Timing
- Acceptance edge at cycle 0.
- MEAN during cycle 1.
- First out_valid in cycle 2, so latency from accept to first beat is 2 cycles.
- With out_ready held high, one beat per cycle. Beats 0..N−1 occupy cycles 2..N+1.
- in_ready returns high in cycle N+2.
- Throughput: one vector per N+2 cycles minimum.
- out_* and in_ready are driven from registered state and idx. out_data is combinational from registers; there is no input-to-output combinational path.
- busy and in_ready are exact complements.

## Structure
- Shared package holds:
  - localparams N, SUM_W = DATA_WIDTH+NUM_QUBIT, MEAN_W = DATA_WIDTH+1.
  - Saturation bounds.
  - FSM state enum {IDLE, MEAN, EMIT}.
- One combinational sub-module, reflect_sat. Inputs: mean (MEAN_W) and amplitude (DATA_WIDTH). Output: saturated 2·mean − a (DATA_WIDTH). It is reused by any future diffusion variant.
- Top level holds the FSM, the vector/sum registers, idx, and the output mux.

## Test plan
- NUM_QUBIT=2, DATA_WIDTH=8, vec {10,20,30,40}, sum 100, out_ready=1:
  - mean 25.
  - Beats 40,30,20,10 in cycles 2–5, indices 0–3.
  - out_last on beat 3. in_ready high in cycle 6.
- Negative floor. Vec {−1,0,0,0}, sum −1:
  - mean −1.
  - Beats −1,−2,−2,−2.
- Saturation. Vec {127,127,127,−128}, sum 253:
  - mean 63.
  - Beats −1,−1,−1, then 254 saturated to 127.
- Backpressure. Vector from the first scenario, with out_ready toggling 1,0,0,1,0,1,1:
  - Beat values and indices are held stable while stalled.
  - Exactly 4 handshakes occur, in order 40,30,20,10.
- Reset mid-stream. Assert rst_n=0 after beat 1 is accepted:
  - out_valid drops the same cycle, asynchronously.
  - After release: in_ready=1, busy=0.
  - A new vector {0,0,0,4} (sum 4) yields beats 2,2,2,−2.
- in_valid held high during EMIT with a different vector:
  - It is ignored and the output stream is unchanged.
  - That vector is accepted on the first IDLE cycle.
